// File: rtl/led_port_pkg.sv
// Shared register map and bus-lane constants for the LED output port.
package led_port_pkg;

   localparam int unsigned LANE_W    = 8;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned BUS_W     = LANE_W * NUM_LANES;

   typedef enum logic [1:0] {
      REG_DATA  = 2'd0,
      REG_SET   = 2'd1,
      REG_CLEAR = 2'd2,
      REG_BLINK = 2'd3
   } reg_addr_e;

   // Expand per-lane byte enables into a per-bit write mask.
   function automatic logic [BUS_W-1:0] lane_mask(input logic [NUM_LANES-1:0] be);
      logic [BUS_W-1:0] m;
      m = '0;
      for (int k = 0; k < int'(NUM_LANES); k++) begin
         m[k*LANE_W +: LANE_W] = {LANE_W{be[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running half-period counter producing the blink phase.
module blink_timer
   import led_port_pkg::*;
#(
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic phase
);

   localparam int unsigned CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);

   logic [CW-1:0] count;

   // Count every clock; restart beats wrap so a rewrite always starts a full lit half-period.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         count <= '0;
         phase <= 1'b1;
      end else if (count == LAST) begin
         count <= '0;
         phase <= ~phase;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/led_output_port.sv
// Memory-mapped LED port with data/set/clear/blink-mask registers.
module led_output_port
   import led_port_pkg::*;
#(
   parameter int DW           = 9,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    address,
   input  logic [3:0]    byteenable,
   input  logic          chipselect,
   input  logic          read,
   input  logic          write,
   input  logic [31:0]   writedata,
   output logic [31:0]   readdata,
   output logic [DW:0]   LEDR
);

   localparam int unsigned W = DW + 1;

   logic [W-1:0]     data;
   logic [W-1:0]     mask;
   logic [BUS_W-1:0] be_bits;
   logic             wr_en;
   logic             rd_en;
   logic             restart;
   logic             phase;

   assign be_bits = lane_mask(byteenable);
   assign wr_en   = chipselect & write;
   assign rd_en   = chipselect & read;
   assign restart = wr_en & (address == REG_BLINK) & (|byteenable);

   blink_timer #(
      .BLINK_CYCLES (BLINK_CYCLES)
   ) u_blink_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .phase   (phase)
   );

   // Register writes, done at bus width so bits above DW simply fall away.
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
         mask <= '0;
      end else if (wr_en) begin
         case (address)
            REG_DATA:  data <= W'((32'(data) & ~be_bits) | (writedata & be_bits));
            REG_SET:   data <= W'(32'(data) | (writedata & be_bits));
            REG_CLEAR: data <= W'(32'(data) & ~(writedata & be_bits));
            REG_BLINK: mask <= W'((32'(mask) & ~be_bits) | (writedata & be_bits));
            default:   ;
         endcase
      end
   end

   // Read data reflects register state before any same-edge write.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd_en) begin
         case (address)
            REG_DATA:  readdata <= 32'(data);
            REG_BLINK: readdata <= 32'(mask);
            default:   readdata <= '0;
         endcase
      end
   end

   // Masked bits go dark during the off phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         LEDR <= '0;
      end else begin
         LEDR <= data & ~(mask & {W{~phase}});
      end
   end

endmodule

// File: doc/led_output_port.md
LED_OUTPUT_PORT -- requirements
Module: led_output_port

Interface
REQ-001 SHALL have parameter DW, default 9: output data width minus 1; legal range 0..31.
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000: clocks per blink half-period; legal range 2..2^26.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port address, input, 2: register select (0 DATA, 1 SET, 2 CLEAR, 3 BLINK).
REQ-006 SHALL have port byteenable, input, 4: write lane enables; lane k covers writedata[8k+7:8k].
REQ-007 SHALL have port chipselect, input, 1: slave selected.
REQ-008 SHALL have port read, input, 1: read strobe, qualified by chipselect.
REQ-009 SHALL have port write, input, 1: write strobe, qualified by chipselect.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port readdata, output, 32: registered read data.
REQ-012 SHALL have port LEDR, output, DW+1: registered LED drive.

Function
REQ-013 SHALL hold internal registers data[DW:0] and mask[DW:0].
REQ-014 SHALL accept a write only when chipselect=1 and write=1; otherwise data and mask are unchanged.
REQ-015 SHALL apply a write only to bits in enabled lanes; bits above DW are ignored; byteenable=0 changes nothing.
REQ-016 SHALL on a DATA write load each enabled data bit from writedata.
REQ-017 SHALL on a SET write OR writedata into the enabled data bits.
REQ-018 SHALL on a CLEAR write clear each enabled data bit whose writedata bit is 1.
REQ-019 SHALL on a BLINK write load each enabled mask bit from writedata, zero the blink counter and set phase=1 in the same edge.
REQ-020 SHALL update readdata only when chipselect=1 and read=1; otherwise readdata holds.
REQ-021 SHALL return: address 0 -> zero-extended data; address 3 -> zero-extended mask; addresses 1 and 2 -> 32'h0.
REQ-022 SHALL present readdata one clock after the read edge; it reflects register contents before any same-edge write.
REQ-023 SHALL run a counter 0..BLINK_CYCLES-1 that increments every clock; at BLINK_CYCLES-1 it wraps to 0 and phase toggles.
REQ-024 SHALL register LEDR <= data & ~(mask & {DW+1{~phase}}) every clock, so a write at edge N appears on LEDR at edge N+1.
REQ-025 SHALL count continuously whether or not mask is zero; mask=0 yields LEDR = data (delayed one clock).
REQ-026 SHALL give a BLINK write priority over wrap on the same edge: counter 0, phase 1.

Reset
REQ-027 SHALL on reset=1 set data=0, mask=0, counter=0, phase=1, readdata=32'h0, LEDR=0 at the next edge.
REQ-028 SHALL ignore any bus write or read coinciding with reset.

Structure
REQ-029 SHALL take register offsets (DATA=0, SET=1, CLEAR=2, BLINK=3) and the lane-width constant (8) from a shared package, led_port_pkg.
REQ-030 SHALL put counter and phase in one sub-module, blink_timer (inputs clk, reset, restart; output phase; parameter BLINK_CYCLES).

Verification (BLINK_CYCLES=4, DW=9)
REQ-031 SHALL cover: reset, then DATA write 32'h3FF with byteenable 4'b0011 -> LEDR 10'h3FF one clock later; readdata 32'h3FF after a DATA read.
REQ-032 SHALL cover: data 10'h0F0; SET 32'h00F; CLEAR 32'h030 -> LEDR 10'h0FF then 10'h0CF; SET/CLEAR reads return 0.
REQ-033 SHALL cover: DATA write 32'hFFFF_FFFF with byteenable 4'b0010 after data=0 -> data 10'h300 only.
REQ-034 SHALL cover: data 10'h3FF, BLINK 32'h001 -> LEDR bit0 high 4 clocks, low 4 clocks, repeating; other bits steady high.
REQ-035 SHALL cover: BLINK rewrite on the counter wrap edge -> phase stays 1, next toggle exactly 4 clocks later.
REQ-036 SHALL cover: reset asserted mid-blink with a write on the same edge -> all registers 0, phase 1, write discarded.
